dino_game_ctrl: RTL

Game-level controller for the 2x8 dino display. It runs the IDLE/RUN/OVER game state machine, scrolls a row-0 obstacle lane toward the dino's column, and detects collisions against the dino row reported by the dino movement block. It also gates jump requests into that block and keeps the score. Its grid output replaces the dino-only grid as the value driven to the display.

---
 rtl/dino_game_ctrl_if.sv | 27 ++
 rtl/dino_game_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dino_game_ctrl_if.sv
// Bundle between the game controller, its buttons, the dino movement block and the display.
// Latency: wires only; the controller drives the outputs combinationally from its registered state.
// Backpressure: none; every signal is a level sampled or driven each clock.
interface dino_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start_button;
  logic               jump_button;
  logic               dino_row;
  logic               dino_hold;
  logic               jump_req;
  logic [15:0]        grid;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  // Environment side: buttons and movement block drive, display consumes.
  modport master (
    output start_button, jump_button, dino_row,
    input  dino_hold, jump_req, grid, score, game_over
  );

  // Controller side.
  modport slave (
    input  start_button, jump_button, dino_row,
    output dino_hold, jump_req, grid, score, game_over
  );
endinterface

// File: rtl/dino_game_ctrl.sv
// Dino game controller: IDLE/RUN/OVER FSM, scrolling obstacle lane, collision detect, score.
// Latency: one lane step every TICK_DIV cycles; game_over rises the cycle after a collision.
// Backpressure: none; optional macro DINO_SPEEDUP_EN shortens the step period as score grows.
module dino_game_ctrl #(
  parameter int         TICK_DIV      = 4,
  parameter int         SCORE_W       = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         SPAWN_GAP_MIN = 3
) (
  input logic             clk,
  input logic             reset,
  dino_game_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int GW = (SPAWN_GAP_MIN < 1) ? 1 : $clog2(SPAWN_GAP_MIN + 1);
  localparam logic [TW-1:0] DIV_INIT  = TW'(TICK_DIV);
  localparam logic [GW-1:0] GAP_MIN   = GW'(SPAWN_GAP_MIN);
  // Galois right-shift taps for x^8+x^6+x^5+x^4+1.
  localparam logic [7:0]    LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         obs_q, obs_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [TW-1:0]      div_cur;
  logic [GW-1:0]      gap_q, gap_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               start_q;
  logic               start_rise;
  logic               collide;
  logic               step;
  logic               spawn;

`ifdef DINO_SPEEDUP_EN
  logic [TW-1:0]      div_q, div_d;
  assign div_cur = div_q;
`else
  assign div_cur = DIV_INIT;
`endif

  assign start_rise = bus.start_button & ~start_q;
  // An obstacle in column 0 only hurts a grounded dino.
  assign collide    = (state_q == RUN) & obs_q[7] & ~bus.dino_row;
  assign step       = (state_q == RUN) & (tick_q == div_cur - 1'b1);
  assign spawn      = lfsr_q[0] & (gap_q >= GAP_MIN);

  // Game state registers; reset forces the idle picture without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      obs_q   <= '0;
      score_q <= '0;
      tick_q  <= '0;
      gap_q   <= GAP_MIN;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b0;
`ifdef DINO_SPEEDUP_EN
      div_q   <= DIV_INIT;
`endif
    end else begin
      state_q <= state_d;
      obs_q   <= obs_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      start_q <= bus.start_button;
`ifdef DINO_SPEEDUP_EN
      div_q   <= div_d;
`endif
    end
  end

  // Next-state: lane scroll, spawning, scoring and game start/stop.
  always_comb begin
    state_d = state_q;
    obs_d   = obs_q;
    score_d = score_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    lfsr_d  = lfsr_q;
`ifdef DINO_SPEEDUP_EN
    div_d   = div_q;
`endif
    case (state_q)
      IDLE: obs_d = '0;
      RUN: begin
        tick_d = step ? '0 : tick_q + 1'b1;
        if (collide) begin
          // Freeze everything at the moment of impact; a coincident step is dropped.
          state_d = OVER;
        end else if (step) begin
          obs_d  = {obs_q[6:0], spawn};
          gap_d  = spawn ? '0 : ((gap_q >= GAP_MIN) ? GAP_MIN : gap_q + 1'b1);
          lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
          // Obstacle leaving column 0 while the dino is airborne counts as cleared.
          if (obs_q[7] && (score_q != '1)) begin
            score_d = score_q + 1'b1;
`ifdef DINO_SPEEDUP_EN
            if ((score_q[2:0] == 3'b111) && (div_q > TW'(2)))
              div_d = div_q - 1'b1;
`endif
          end
        end
      end
      OVER: ;
      default: state_d = IDLE;
    endcase

    // A fresh start from IDLE or OVER restarts the game from a clean slate.
    if ((state_q != RUN) && start_rise) begin
      state_d = RUN;
      obs_d   = '0;
      score_d = '0;
      tick_d  = '0;
      gap_d   = '0;
      lfsr_d  = LFSR_SEED;
`ifdef DINO_SPEEDUP_EN
      div_d   = DIV_INIT;
`endif
    end
  end

  logic [15:0] grid_c;
  logic        hold_c;
  logic        jreq_c;
  logic        over_c;

  // Display image and per-state controls toward the movement block.
  always_comb begin
    hold_c = 1'b0;
    jreq_c = 1'b0;
    over_c = 1'b0;
    grid_c = {(bus.dino_row ? 8'h80 : 8'h00), (obs_q | (bus.dino_row ? 8'h00 : 8'h80))};
    case (state_q)
      IDLE: begin
        hold_c = 1'b1;
        grid_c = 16'h0080;
      end
      RUN:  jreq_c = bus.jump_button;
      OVER: over_c = 1'b1;
      default: begin
        hold_c = 1'b1;
        grid_c = 16'h0080;
      end
    endcase
  end

  assign bus.grid      = grid_c;
  assign bus.score     = score_q;
  assign bus.game_over = over_c;
  assign bus.dino_hold = hold_c;
  assign bus.jump_req  = jreq_c;

endmodule
